// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl
//
// Purpose: sequences a downstream 16x8 RAM through two commands.
//   FILL writes (fill_base + k) mod 256 to address k for k = 0..15.
//   SCAN reads all 16 bytes and reports their unsigned sum and maximum.
//   Results are published only when a SCAN completes. They hold through
//   FILL commands and idle time.
//
// Parameters:
//   RD_LAT     RAM read latency in clocks, from addr to valid rd_data (1..3)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      single-cycle command request (ignored unless idle)
//   op         command select sampled with start: 0 = FILL, 1 = SCAN
//   fill_base  fill seed sampled with start
//   rd_data    RAM read data
//   addr       shared RAM read/write address
//   wr_en      RAM write enable
//   wr_data    RAM write data
//   busy       high in FILL, SCAN and DRAIN
//   done       one-cycle pulse at the end of a command
//   sum        sum of the 16 bytes read by the last SCAN
//   max_val    largest byte read by the last SCAN
module ram_seq_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [7:0]  fill_base,
    input  logic [7:0]  rd_data,
    output logic [3:0]  addr,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [11:0] sum,
    output logic [7:0]  max_val
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  addr_reg, addr_next;
    logic        wr_en_reg, wr_en_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [11:0] sum_reg, sum_next;
    logic [7:0]  max_reg, max_next;
    logic [7:0]  base_reg, base_next;
    logic [11:0] acc_sum_reg, acc_sum_next;
    logic [7:0]  acc_max_reg, acc_max_next;
    logic [3:0]  samp_cnt_reg, samp_cnt_next;

    // Read-valid pipeline. Bit 0 is set in the cycle after a SCAN address
    // is presented. The last bit therefore marks the cycle in which
    // rd_data belongs to the address issued RD_LAT cycles earlier.
    logic [RD_LAT-1:0] vpipe_reg, vpipe_next;

    assign vpipe_next[0] = (state_reg == ST_SCAN);

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vpipe
            assign vpipe_next[gi] = vpipe_reg[gi-1];
        end
    endgenerate

    logic        sample_valid;
    logic [3:0]  addr_inc;
    logic [11:0] acc_sum_upd;
    logic [7:0]  acc_max_upd;

    assign sample_valid = vpipe_reg[RD_LAT-1];
    assign addr_inc     = addr_reg + 4'd1;
    assign acc_sum_upd  = acc_sum_reg + {4'd0, rd_data};
    assign acc_max_upd  = (rd_data > acc_max_reg) ? rd_data : acc_max_reg;

    always_comb begin
        state_next    = state_reg;
        addr_next     = 4'd0;
        wr_en_next    = 1'b0;
        wr_data_next  = 8'h00;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        sum_next      = sum_reg;
        max_next      = max_reg;
        base_next     = base_reg;
        acc_sum_next  = acc_sum_reg;
        acc_max_next  = acc_max_reg;
        samp_cnt_next = samp_cnt_reg;

        if (sample_valid) begin
            acc_sum_next  = acc_sum_upd;
            acc_max_next  = acc_max_upd;
            samp_cnt_next = samp_cnt_reg + 4'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    base_next = fill_base;
                    busy_next = 1'b1;
                    if (!op) begin
                        state_next   = ST_FILL;
                        wr_en_next   = 1'b1;
                        wr_data_next = fill_base;
                    end else begin
                        state_next    = ST_SCAN;
                        acc_sum_next  = 12'd0;
                        acc_max_next  = 8'h00;
                        samp_cnt_next = 4'd0;
                    end
                end
            end
            ST_FILL: begin
                if (addr_reg == 4'd15) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next    = 1'b1;
                    addr_next    = addr_inc;
                    wr_en_next   = 1'b1;
                    wr_data_next = base_reg + {4'd0, addr_inc};
                end
            end
            ST_SCAN: begin
                busy_next = 1'b1;
                if (addr_reg == 4'd15) begin
                    // Hold the last address while the final reads drain.
                    // The counter wraps only when the command ends.
                    state_next = ST_DRAIN;
                    addr_next  = addr_reg;
                end else begin
                    addr_next = addr_inc;
                end
            end
            ST_DRAIN: begin
                if (sample_valid && samp_cnt_reg == 4'd15) begin
                    // Publish using the accumulator value that includes
                    // the 16th sample, which arrives in this cycle.
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    sum_next   = acc_sum_upd;
                    max_next   = acc_max_upd;
                end else begin
                    busy_next = 1'b1;
                    addr_next = addr_reg;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= 4'd0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sum_reg      <= 12'd0;
            max_reg      <= 8'h00;
            base_reg     <= 8'h00;
            acc_sum_reg  <= 12'd0;
            acc_max_reg  <= 8'h00;
            samp_cnt_reg <= 4'd0;
            vpipe_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wr_en_reg    <= wr_en_next;
            wr_data_reg  <= wr_data_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            sum_reg      <= sum_next;
            max_reg      <= max_next;
            base_reg     <= base_next;
            acc_sum_reg  <= acc_sum_next;
            acc_max_reg  <= acc_max_next;
            samp_cnt_reg <= samp_cnt_next;
            vpipe_reg    <= vpipe_next;
        end
    end

    assign addr    = addr_reg;
    assign wr_en   = wr_en_reg;
    assign wr_data = wr_data_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign sum     = sum_reg;
    assign max_val = max_reg;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl
//
// Three controllers with RD_LAT = 1, 2 and 3 share one command stream.
// Each controller drives its own 16x8 RAM model.
// Expected writes and done events are queued when a command is issued.
// A negedge monitor pops the queues and compares them with what each
// controller actually does.
module tb_ram_seq_ctrl;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [7:0]  fill_base = 8'h00;

    logic [7:0]  rd_a      [N];
    logic [3:0]  addr_a    [N];
    logic        wr_en_a   [N];
    logic [7:0]  wr_data_a [N];
    logic        busy_a    [N];
    logic        done_a    [N];
    logic [11:0] sum_a     [N];
    logic [7:0]  max_a     [N];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [11:0] s;
        logic [7:0]  m;
    } dn_t;

    wr_t wq [N][$];
    dn_t dnq[N][$];
    wr_t we;
    dn_t de;

    // Reference state: RAM contents and the last published SCAN result.
    logic [7:0]  mem_m [16];
    logic [11:0] last_sum = 12'd0;
    logic [7:0]  last_max = 8'h00;
    logic [11:0] held_sum [N];
    logic [7:0]  held_max [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam int L = gi + 1;
            logic [7:0] mem [16];
            logic [7:0] dly [L];

            ram_seq_ctrl #(.RD_LAT(L)) dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start),
                .op        (op),
                .fill_base (fill_base),
                .rd_data   (rd_a[gi]),
                .addr      (addr_a[gi]),
                .wr_en     (wr_en_a[gi]),
                .wr_data   (wr_data_a[gi]),
                .busy      (busy_a[gi]),
                .done      (done_a[gi]),
                .sum       (sum_a[gi]),
                .max_val   (max_a[gi])
            );

            always @(posedge clk) begin
                if (wr_en_a[gi]) mem[addr_a[gi]] <= wr_data_a[gi];
                dly[0] <= mem[addr_a[gi]];
                for (int j = 1; j < L; j++) dly[j] <= dly[j-1];
            end
            assign rd_a[gi] = dly[L-1];
        end
    endgenerate

    // Monitor: compare every write and every done pulse with the queues.
    // Between done pulses, also check that the published result holds.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (wr_en_a[i]) begin
                    checks++;
                    if (wq[i].size() == 0) begin
                        errors++;
                        $display("FAIL write dut%0d: unexpected write addr=%0d data=%02h at cyc=%0d, expected none",
                                 i, addr_a[i], wr_data_a[i], cyc);
                    end else begin
                        we = wq[i].pop_front();
                        if (we.cyc != cyc || we.a != addr_a[i] || we.d != wr_data_a[i]) begin
                            errors++;
                            $display("FAIL write dut%0d: got cyc=%0d addr=%0d data=%02h, expected cyc=%0d addr=%0d data=%02h",
                                     i, cyc, addr_a[i], wr_data_a[i], we.cyc, we.a, we.d);
                        end
                    end
                end
                if (done_a[i]) begin
                    checks++;
                    if (dnq[i].size() == 0) begin
                        errors++;
                        $display("FAIL done dut%0d: unexpected done at cyc=%0d, expected none", i, cyc);
                    end else begin
                        de = dnq[i].pop_front();
                        if (de.cyc != cyc || de.s != sum_a[i] || de.m != max_a[i] || busy_a[i] !== 1'b0) begin
                            errors++;
                            $display("FAIL done dut%0d: got cyc=%0d sum=%0d max=%02h busy=%b, expected cyc=%0d sum=%0d max=%02h busy=0",
                                     i, cyc, sum_a[i], max_a[i], busy_a[i], de.cyc, de.s, de.m);
                        end
                        held_sum[i] = de.s;
                        held_max[i] = de.m;
                    end
                end else begin
                    checks++;
                    if (sum_a[i] !== held_sum[i] || max_a[i] !== held_max[i]) begin
                        errors++;
                        $display("FAIL hold dut%0d: got sum=%0d max=%02h at cyc=%0d, expected sum=%0d max=%02h",
                                 i, sum_a[i], max_a[i], cyc, held_sum[i], held_max[i]);
                    end
                end
            end
        end
    end

    // Issue a command at the current negedge. The reference model then
    // queues the expected writes and the expected done event.
    task automatic issue(input logic o, input logic [7:0] b);
        int e;
        int s;
        logic [7:0] m;
        start = 1'b1;
        op = o;
        fill_base = b;
        e = cyc;
        if (!o) begin
            for (int k = 0; k < 16; k++) begin
                mem_m[k] = 8'(b + k);
                for (int i = 0; i < N; i++)
                    wq[i].push_back('{e + 1 + k, 4'(k), 8'(b + k)});
            end
            for (int i = 0; i < N; i++)
                dnq[i].push_back('{e + 17, last_sum, last_max});
        end else begin
            s = 0;
            m = 8'h00;
            for (int k = 0; k < 16; k++) begin
                s += int'(mem_m[k]);
                if (mem_m[k] > m) m = mem_m[k];
            end
            last_sum = 12'(s);
            last_max = m;
            for (int i = 0; i < N; i++)
                dnq[i].push_back('{e + 17 + i + 1, last_sum, last_max});
        end
        $display("cmd %s base=%02h issued at cyc=%0d", o ? "SCAN" : "FILL", b, e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        bit empty;
        empty = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int i = 0; i < N; i++)
                if (wq[i].size() != 0 || dnq[i].size() != 0) empty = 1'b0;
            if (empty) break;
        end
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain: expected events still pending at cyc=%0d, required none", cyc);
            for (int i = 0; i < N; i++) begin
                wq[i].delete();
                dnq[i].delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (addr_a[i] !== 4'd0 || wr_en_a[i] !== 1'b0 || wr_data_a[i] !== 8'h00 ||
                busy_a[i] !== 1'b0 || done_a[i] !== 1'b0 || sum_a[i] !== 12'd0 || max_a[i] !== 8'h00) begin
                errors++;
                $display("FAIL %s dut%0d: got addr=%0d wr_en=%b wr_data=%02h busy=%b done=%b sum=%0d max=%02h, expected all zero",
                         tag, i, addr_a[i], wr_en_a[i], wr_data_a[i], busy_a[i], done_a[i], sum_a[i], max_a[i]);
            end
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < N; i++) begin
            held_sum[i] = 12'd0;
            held_max[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Release reset and request in the same cycle. The first edge
        // with rst=0 must accept the command.
        rst = 1'b0;
        issue(1'b0, 8'hF0);
        wait_drain();
        issue(1'b1, 8'h00);
        wait_drain();

        // Wrapping fill, plus a start pulse at cycle 5 that must be ignored.
        issue(1'b0, 8'hFA);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 1'b1;
        fill_base = 8'h33;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        issue(1'b1, 8'h00);
        wait_drain();

        // Randomized command mix.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), 8'($urandom));
            wait_drain();
        end

        // Reset while the 8th SCAN address is on the bus.
        issue(1'b1, 8'h00);
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (addr_a[0] == 4'd7 && busy_a[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midscan: addr 7 not reached, got addr=%0d, expected 7", addr_a[0]);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            wq[i].delete();
            dnq[i].delete();
            held_sum[i] = 12'd0;
            held_max[i] = 8'h00;
        end
        last_sum = 12'd0;
        last_max = 8'h00;
        #1;
        check_reset_state("midscan_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_reset_state("after_abort");

        // Recovery after the abort.
        issue(1'b0, 8'h5C);
        wait_drain();
        issue(1'b1, 8'h00);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cyc=%0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_seq_ctrl.md
RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameter RD_LAT, default 2, is the read latency in clocks from the address driven on addr to valid data on rd_data; the legal range is 1..3.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  is an asynchronous, active-high reset.
REQ-004 start  input  1  is a single-cycle command request, sampled on the rising edge of clk.
REQ-005 op  input  1  selects the command, sampled with start: 0 = FILL, 1 = SCAN.
REQ-006 fill_base  input  8  is the fill seed, sampled with start.
REQ-007 rd_data  input  8  is the read data returned by the downstream 16x8 RAM.
REQ-008 addr  output  4  is the shared read/write address to the RAM.
REQ-009 wr_en  output  1  is the RAM write enable.
REQ-010 wr_data  output  8  is the RAM write data.
REQ-011 busy  output  1  is high while a command is in progress.
REQ-012 done  output  1  is a one-cycle pulse marking the end of a command.
REQ-013 sum  output  12  is the unsigned sum of the 16 bytes from the last SCAN.
REQ-014 max_val  output  8  is the largest byte from the last SCAN.

Function
REQ-015 The FSM states shall be IDLE, FILL, SCAN, DRAIN and DONE, and all outputs shall be registered.
REQ-016 IDLE: on start=1, go to FILL if op=0 or to SCAN if op=1; capture fill_base; set the address counter to 0.
REQ-017 start while busy=1 or in DONE shall be ignored, with no queuing.
REQ-018 FILL: for 16 consecutive cycles drive wr_en=1, addr=k and wr_data=(fill_base+k) mod 256, for k=0..15; after k=15, go to DONE.
REQ-019 SCAN: for 16 consecutive cycles drive wr_en=0 and addr=k, for k=0..15; after k=15, go to DRAIN.
REQ-020 A read-valid pipeline of depth RD_LAT shall mark rd_data valid RD_LAT cycles after each SCAN address is issued; exactly 16 samples shall be accepted per SCAN.
REQ-021 On SCAN entry, clear the sum accumulator to 0 and the max accumulator to 0x00.
REQ-022 On each valid sample, the accumulator shall update as acc_sum += rd_data, zero-extended to 12 bits; the maximum 16*255 = 4080 cannot overflow.
REQ-023 On each valid sample, acc_max = max(acc_max, rd_data), compared unsigned.
REQ-024 DRAIN shall remain until the 16th sample is accepted (RD_LAT cycles), then go to DONE.
REQ-025 DONE shall last one cycle with done=1, busy=0 and wr_en=0, then return to IDLE.
REQ-026 sum and max_val shall update only in the DONE cycle after a SCAN, and shall hold through FILL commands and idle time.
REQ-027 busy=1 exactly in FILL, SCAN and DRAIN.
REQ-028 The address counter shall wrap 15 -> 0 only at command end, and addr shall read 0 in IDLE.
REQ-029 In IDLE and DONE, drive wr_en=0 and wr_data=0x00.
REQ-030 A FILL command shall take 17 cycles from start to done; a SCAN command shall take 17+RD_LAT cycles.

Reset
REQ-031 rst=1 shall immediately force IDLE with addr=0, wr_en=0, wr_data=0x00, busy=0, done=0, sum=0, max_val=0x00, and shall flush the valid pipeline, independent of clk.
REQ-032 When rst is asserted mid-command, the command shall be aborted with no done pulse and no partial result; a write in flight shall not complete after rst rises.
REQ-033 After rst is released, the first start accepted shall be the one sampled on the first rising edge with rst=0.

Verification
REQ-034 FILL: start, op=0, fill_base=0xF0 -> writes 0xF0..0xFF to addr 0..15 on consecutive cycles; done 17 cycles after start.
REQ-035 FILL wrap: fill_base=0xFA -> addr 5 receives 0xFF, addr 6 receives 0x00, addr 15 receives 0x09.
REQ-036 SCAN: with RAM holding 0xF0..0xFF and RD_LAT=2 -> sum=0xF78 (3960), max_val=0xFF; done 19 cycles after start.
REQ-037 Ignored start: start pulsed at cycle 5 of a FILL -> one command only, one done pulse, no restart.
REQ-038 Reset mid-SCAN: rst at the 8th SCAN address -> wr_en=0, busy=0 at once; no done; sum and max_val read 0 afterwards.
REQ-039 Latency sweep: repeat the SCAN test with RD_LAT=1 and RD_LAT=3 -> identical sum and max; done at 18 and 20 cycles respectively.
